// File: rtl/riscv_arb_pkg.sv
// Shared encodings for the I/D line-refill arbiter: FSM states, one-hot grants
// and memory operation codes.
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_D = 2'b01;
    localparam logic [1:0] GNT_I = 2'b10;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/riscv_arb_rr.sv
// Two-way round-robin picker: combinational one-hot grant, with the last-granted
// side remembered so the other side wins the next tie.
module riscv_arb_rr
    import riscv_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_d,
    input  logic       req_i,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_was_i;

    always_comb begin
        grant = 2'b00;
        if (req_d && req_i) begin
            grant = last_was_i ? GNT_D : GNT_I;
        end else if (req_d) begin
            grant = GNT_D;
        end else if (req_i) begin
            grant = GNT_I;
        end
    end

    // Starting from "last was I" makes the D side win the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_was_i <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            last_was_i <= (grant == GNT_I);
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Serialises I-cache and D-cache line transactions onto one shared main-memory
// port; returns read lines and a one-cycle ready pulse to the winning side.
module riscv_mem_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int S_ADDR     = 10
) (
    input  logic                  i_riscv_clk,
    input  logic                  i_riscv_rst,

    input  logic                  i_riscv_arb_dmem_wren,
    input  logic                  i_riscv_arb_dmem_rden,
    input  logic [S_ADDR-1:0]     i_riscv_arb_dmem_addr,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_dmem_wdata,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_dmem_rdata,
    output logic                  o_riscv_arb_dmem_ready,

    input  logic                  i_riscv_arb_imem_rden,
    input  logic [S_ADDR-1:0]     i_riscv_arb_imem_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_imem_rdata,
    output logic                  o_riscv_arb_imem_ready,

    output logic                  o_riscv_arb_mem_wren,
    output logic                  o_riscv_arb_mem_rden,
    output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_rdata,
    input  logic                  i_riscv_arb_mem_ready
);

    arb_state_t state;
    logic       cur_op;
    logic       d_req;
    logic       sample;
    logic [1:0] grant;

    assign d_req  = i_riscv_arb_dmem_wren | i_riscv_arb_dmem_rden;
    assign sample = (state == IDLE);

    riscv_arb_rr u_rr (
        .clk    (i_riscv_clk),
        .rst    (i_riscv_rst),
        .req_d  (d_req),
        .req_i  (i_riscv_arb_imem_rden),
        .update (sample),
        .grant  (grant)
    );

    // DONE both pulses ready and gives requesters a cycle to drop their level
    // requests before IDLE samples again.
    always_ff @(posedge i_riscv_clk) begin
        if (i_riscv_rst) begin
            state                  <= IDLE;
            cur_op                 <= OP_RD;
            o_riscv_arb_mem_wren   <= 1'b0;
            o_riscv_arb_mem_rden   <= 1'b0;
            o_riscv_arb_mem_addr   <= '0;
            o_riscv_arb_mem_wdata  <= '0;
            o_riscv_arb_dmem_rdata <= '0;
            o_riscv_arb_imem_rdata <= '0;
            o_riscv_arb_dmem_ready <= 1'b0;
            o_riscv_arb_imem_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant == GNT_D) begin
                        state                 <= DSERV;
                        cur_op                <= i_riscv_arb_dmem_wren ? OP_WR : OP_RD;
                        o_riscv_arb_mem_wren  <= i_riscv_arb_dmem_wren;
                        o_riscv_arb_mem_rden  <= ~i_riscv_arb_dmem_wren;
                        o_riscv_arb_mem_addr  <= i_riscv_arb_dmem_addr;
                        o_riscv_arb_mem_wdata <= i_riscv_arb_dmem_wdata;
                    end else if (grant == GNT_I) begin
                        state                 <= ISERV;
                        cur_op                <= OP_RD;
                        o_riscv_arb_mem_wren  <= 1'b0;
                        o_riscv_arb_mem_rden  <= 1'b1;
                        o_riscv_arb_mem_addr  <= i_riscv_arb_imem_addr;
                        o_riscv_arb_mem_wdata <= '0;
                    end
                end
                DSERV: begin
                    if (i_riscv_arb_mem_ready) begin
                        o_riscv_arb_mem_wren   <= 1'b0;
                        o_riscv_arb_mem_rden   <= 1'b0;
                        o_riscv_arb_dmem_ready <= 1'b1;
                        state                  <= DONE;
                        if (cur_op == OP_RD) begin
                            o_riscv_arb_dmem_rdata <= i_riscv_arb_mem_rdata;
                        end
                    end
                end
                ISERV: begin
                    if (i_riscv_arb_mem_ready) begin
                        o_riscv_arb_mem_wren   <= 1'b0;
                        o_riscv_arb_mem_rden   <= 1'b0;
                        o_riscv_arb_imem_ready <= 1'b1;
                        o_riscv_arb_imem_rdata <= i_riscv_arb_mem_rdata;
                        state                  <= DONE;
                    end
                end
                DONE: begin
                    o_riscv_arb_dmem_ready <= 1'b0;
                    o_riscv_arb_imem_ready <= 1'b0;
                    state                  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model and memory image.
module tb_riscv_mem_arbiter;

    localparam int DW = 128;
    localparam int AW = 10;
    localparam int SIDE_NONE = 0;
    localparam int SIDE_D    = 1;
    localparam int SIDE_I    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          dmem_wren, dmem_rden;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          dmem_ready;
    logic          imem_rden;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          imem_ready;
    logic          mem_wren, mem_rden;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] dram    [0:1023];
    logic [DW-1:0] ref_mem [0:1023];

    bit mem_auto     = 1'b0;
    bit mem_lat_rand = 1'b0;
    int mem_lat      = 2;
    int mem_cnt      = 0;
    int cur_lat      = 1;

    bit d_done, i_done;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.DATA_WIDTH(DW), .S_ADDR(AW)) dut (
        .i_riscv_clk            (clk),
        .i_riscv_rst            (rst),
        .i_riscv_arb_dmem_wren  (dmem_wren),
        .i_riscv_arb_dmem_rden  (dmem_rden),
        .i_riscv_arb_dmem_addr  (dmem_addr),
        .i_riscv_arb_dmem_wdata (dmem_wdata),
        .o_riscv_arb_dmem_rdata (dmem_rdata),
        .o_riscv_arb_dmem_ready (dmem_ready),
        .i_riscv_arb_imem_rden  (imem_rden),
        .i_riscv_arb_imem_addr  (imem_addr),
        .o_riscv_arb_imem_rdata (imem_rdata),
        .o_riscv_arb_imem_ready (imem_ready),
        .o_riscv_arb_mem_wren   (mem_wren),
        .o_riscv_arb_mem_rden   (mem_rden),
        .o_riscv_arb_mem_addr   (mem_addr),
        .o_riscv_arb_mem_wdata  (mem_wdata),
        .i_riscv_arb_mem_rdata  (mem_rdata),
        .i_riscv_arb_mem_ready  (mem_ready)
    );

    function automatic logic [DW-1:0] init_line(input int a);
        return {32'(a) * 32'h9E3779B1, ~32'(a), 32'(a) ^ 32'h5A5A5A5A, 32'hC0DE0000 | 32'(a)};
    endfunction

    // Memory model: counts cycles of a held request and pulses ready after the latency.
    initial begin : mem_responder
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_auto) begin
                if (mem_rden || mem_wren) begin
                    mem_cnt++;
                    if (mem_cnt == 1) cur_lat = mem_lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
                    if (mem_cnt == cur_lat) begin
                        mem_ready = 1'b1;
                        if (mem_wren) begin
                            dram[mem_addr] = mem_wdata;
                            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                        end else begin
                            mem_rdata = dram[mem_addr];
                        end
                    end else begin
                        mem_ready = 1'b0;
                    end
                end else begin
                    mem_cnt   = 0;
                    mem_ready = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_auto(input bit en);
        mem_auto  = en;
        mem_cnt   = 0;
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dmem_wren = 1'b0; dmem_rden = 1'b0; imem_rden = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_auto(1'b1);
        mem_lat_rand = 1'b0;
        mem_lat = 2;
        rst = 1'b1;
        dmem_rden = 1'b1; dmem_wren = 1'b0; dmem_addr = 10'h2C3;
        dmem_wdata = '0;
        imem_rden = 1'b1; imem_addr = 10'h04E;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({mem_rden, mem_wren, mem_addr, mem_wdata, dmem_ready, imem_ready, dmem_rdata, imem_rdata} !== '0) begin
                failures++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %h, want 0", c,
                         {mem_rden, mem_wren, mem_addr, mem_wdata, dmem_ready, imem_ready, dmem_rdata, imem_rdata});
            end
        end
        rst = 1'b0;
        checks++;
        if (mem_rden !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_no_early_grant: mem_rden=%b want 0", mem_rden);
        end
        tick();
        checks++;
        if ({mem_rden, mem_wren, mem_addr} !== {1'b1, 1'b0, 10'h2C3}) begin
            failures++;
            $display("[TB] FAIL reset_first_grant: rden/wren/addr=%b/%b/%h want 1/0/2c3", mem_rden, mem_wren, mem_addr);
        end
        dmem_rden = 1'b0; imem_rden = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_d_read();
        do_reset();
        mem_lat = 3;
        dram[10'h155] = {16{8'hA5}};
        dmem_rden = 1'b1; dmem_wren = 1'b0; dmem_addr = 10'h155;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (imem_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL dread_imem_ready cycle %0d: got %b want 0", c, imem_ready);
            end
            if (c <= 3) begin
                checks++;
                if ({mem_rden, mem_wren, mem_addr, dmem_ready} !== {1'b1, 1'b0, 10'h155, 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL dread_mem_req cycle %0d: rden/wren/addr/ready=%b/%b/%h/%b want 1/0/155/0",
                             c, mem_rden, mem_wren, mem_addr, dmem_ready);
                end
            end else if (c == 4) begin
                checks++;
                if ({mem_rden, dmem_ready, dmem_rdata} !== {1'b0, 1'b1, {16{8'hA5}}}) begin
                    failures++;
                    $display("[TB] FAIL dread_response: rden/ready=%b/%b rdata=%h want 0/1 a5..a5",
                             mem_rden, dmem_ready, dmem_rdata);
                end
                dmem_rden = 1'b0;
            end else begin
                checks++;
                if ({dmem_ready, dmem_rdata, imem_rdata} !== {1'b0, {16{8'hA5}}, 128'h0}) begin
                    failures++;
                    $display("[TB] FAIL dread_after: ready=%b drdata=%h irdata=%h want 0 a5..a5 0",
                             dmem_ready, dmem_rdata, imem_rdata);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] line10;
        do_reset();
        mem_lat = 2;
        line10 = {32'hC0FFEE01, 32'h12345678, 32'h9ABCDEF0, 32'h0BADF00D};
        dram[10'h010] = line10;
        imem_rden = 1'b1; imem_addr = 10'h010;
        dmem_wren = 1'b1; dmem_rden = 1'b0; dmem_addr = 10'h020; dmem_wdata = 128'h1234;
        tick();
        checks++;
        if ({mem_wren, mem_rden, mem_addr, mem_wdata} !== {1'b1, 1'b0, 10'h020, 128'h1234}) begin
            failures++;
            $display("[TB] FAIL simul_d_first: wren/rden/addr/wdata=%b/%b/%h/%h want 1/0/020/1234",
                     mem_wren, mem_rden, mem_addr, mem_wdata);
        end
        tick();
        tick();
        checks++;
        if ({dmem_ready, imem_ready, mem_wren, dmem_rdata} !== {1'b1, 1'b0, 1'b0, 128'h0}) begin
            failures++;
            $display("[TB] FAIL simul_d_ready: dready/iready/wren=%b/%b/%b drdata=%h want 1/0/0 0",
                     dmem_ready, imem_ready, mem_wren, dmem_rdata);
        end
        dmem_wren = 1'b0;
        tick();
        checks++;
        if ({mem_rden, mem_wren, dmem_ready} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL simul_gap: rden/wren/dready=%b/%b/%b want 0/0/0", mem_rden, mem_wren, dmem_ready);
        end
        tick();
        checks++;
        if ({mem_rden, mem_wren, mem_addr} !== {1'b1, 1'b0, 10'h010}) begin
            failures++;
            $display("[TB] FAIL simul_i_grant: rden/wren/addr=%b/%b/%h want 1/0/010", mem_rden, mem_wren, mem_addr);
        end
        tick();
        tick();
        checks++;
        if ({imem_ready, dmem_ready, imem_rdata} !== {1'b1, 1'b0, line10}) begin
            failures++;
            $display("[TB] FAIL simul_i_ready: iready/dready=%b/%b irdata=%h want 1/0 %h",
                     imem_ready, dmem_ready, imem_rdata, line10);
        end
        imem_rden = 1'b0;
        tick();
        checks++;
        if ({imem_ready, dram[10'h020]} !== {1'b0, 128'h1234}) begin
            failures++;
            $display("[TB] FAIL simul_writeback: iready=%b mem[020]=%h want 0 1234", imem_ready, dram[10'h020]);
        end
    endtask

    task automatic test_round_robin();
        int  found;
        int  side;
        int  cyc;
        bit  prev_rd;
        do_reset();
        mem_lat_rand = 1'b1;
        dmem_rden = 1'b1; dmem_wren = 1'b0; dmem_addr = 10'h2AA;
        imem_rden = 1'b1; imem_addr = 10'h0AA;
        found = 0; cyc = 0; prev_rd = 1'b0;
        while (found < 6 && cyc < 200) begin
            tick();
            cyc++;
            if (mem_rden && !prev_rd) begin
                side = (mem_addr == 10'h2AA) ? SIDE_D : SIDE_I;
                checks++;
                if (side != ((found % 2 == 0) ? SIDE_D : SIDE_I)) begin
                    failures++;
                    $display("[TB] FAIL rr_order grant %0d: got side %0d want %0d", found, side,
                             (found % 2 == 0) ? SIDE_D : SIDE_I);
                end
                found++;
            end
            prev_rd = mem_rden;
        end
        checks++;
        if (found != 6) begin
            failures++;
            $display("[TB] FAIL rr_timeout: got %0d grants want 6", found);
        end
        dmem_rden = 1'b0; imem_rden = 1'b0;
        mem_lat_rand = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_auto(1'b0);
        imem_rden = 1'b1; imem_addr = 10'h033;
        tick();
        checks++;
        if ({mem_rden, mem_addr} !== {1'b1, 10'h033}) begin
            failures++;
            $display("[TB] FAIL midrst_serving: rden/addr=%b/%h want 1/033", mem_rden, mem_addr);
        end
        tick();
        rst = 1'b1;
        imem_rden = 1'b0;
        tick();
        checks++;
        if ({mem_rden, mem_wren} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL midrst_drop: rden/wren=%b/%b want 0/0", mem_rden, mem_wren);
        end
        rst = 1'b0;
        tick();
        mem_ready = 1'b1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        tick();
        mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({imem_ready, dmem_ready, mem_rden, imem_rdata} !== {3'b000, 128'h0}) begin
                failures++;
                $display("[TB] FAIL midrst_late_ready: iready/dready/rden=%b/%b/%b irdata=%h want 0/0/0 0",
                         imem_ready, dmem_ready, mem_rden, imem_rdata);
            end
            tick();
        end
        set_auto(1'b1);
    endtask

    task automatic test_spurious_ready();
        do_reset();
        set_auto(1'b0);
        mem_lat = 2;
        mem_ready = 1'b1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        tick();
        mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({dmem_ready, imem_ready, mem_rden, mem_wren, dmem_rdata, imem_rdata} !== {4'b0000, 256'h0}) begin
                failures++;
                $display("[TB] FAIL spurious_ready cycle %0d: dr/ir/rden/wren=%b/%b/%b/%b rdata d=%h i=%h want 0",
                         c, dmem_ready, imem_ready, mem_rden, mem_wren, dmem_rdata, imem_rdata);
            end
            if (c == 0) tick();
        end
        set_auto(1'b1);
        imem_rden = 1'b1; imem_addr = 10'h101;
        tick();
        checks++;
        if ({mem_rden, mem_addr} !== {1'b1, 10'h101}) begin
            failures++;
            $display("[TB] FAIL spurious_still_idle: rden/addr=%b/%h want 1/101", mem_rden, mem_addr);
        end
        imem_rden = 1'b0;
        repeat (6) tick();
    endtask

    task automatic drive_d(input int n);
        int waited;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            dmem_addr  = 10'($urandom_range(0, 1023));
            dmem_wdata = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       begin dmem_wren = 1'b1; dmem_rden = 1'b1; end
                1, 2, 3: begin dmem_wren = 1'b1; dmem_rden = 1'b0; end
                default: begin dmem_wren = 1'b0; dmem_rden = 1'b1; end
            endcase
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!dmem_ready && waited < 60);
            checks++;
            if (!dmem_ready) begin
                failures++;
                $display("[TB] FAIL rand_d_timeout txn %0d: ready=%b want 1 within 60 cycles", k, dmem_ready);
            end
            dmem_wren = 1'b0; dmem_rden = 1'b0;
        end
        d_done = 1'b1;
    endtask

    task automatic drive_i(input int n);
        int waited;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            imem_addr = 10'($urandom_range(0, 1023));
            imem_rden = 1'b1;
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!imem_ready && waited < 60);
            checks++;
            if (!imem_ready) begin
                failures++;
                $display("[TB] FAIL rand_i_timeout txn %0d: ready=%b want 1 within 60 cycles", k, imem_ready);
            end
            imem_rden = 1'b0;
        end
        i_done = 1'b1;
    endtask

    // Transaction-level model: grant rule from the requests seen in the sampling
    // cycle, a reference memory image, and the line each side last received.
    task automatic test_random();
        bit            p_d_req, p_d_wr, p_i_req, p_mem_req, p_mem_ready, last_d;
        logic [AW-1:0] p_d_addr, p_i_addr, pend_addr, exp_addr;
        logic [DW-1:0] p_d_wdata, pend_wdata, exp_d, exp_i;
        int            pend_side, exp_side, n_grants;
        bit            pend_wr, exp_wr;
        do_reset();
        for (int a = 0; a < 1024; a++) begin
            dram[a]    = init_line(a);
            ref_mem[a] = init_line(a);
        end
        mem_lat_rand = 1'b1;
        d_done = 1'b0; i_done = 1'b0;
        p_d_req = 0; p_d_wr = 0; p_i_req = 0; p_mem_req = 0; p_mem_ready = 0;
        p_d_addr = '0; p_i_addr = '0; p_d_wdata = '0;
        last_d = 1'b0; pend_side = SIDE_NONE; pend_wr = 0; pend_addr = '0; pend_wdata = '0;
        exp_d = '0; exp_i = '0; n_grants = 0;
        fork
            drive_d(12);
            drive_i(12);
            begin
                while (!(d_done && i_done)) begin
                    @(negedge clk);
                    if ((mem_rden || mem_wren) && !p_mem_req) begin
                        if (p_d_req && p_i_req) exp_side = last_d ? SIDE_I : SIDE_D;
                        else if (p_d_req)       exp_side = SIDE_D;
                        else if (p_i_req)       exp_side = SIDE_I;
                        else                    exp_side = SIDE_NONE;
                        exp_addr = (exp_side == SIDE_D) ? p_d_addr : p_i_addr;
                        exp_wr   = (exp_side == SIDE_D) && p_d_wr;
                        checks++;
                        if (exp_side == SIDE_NONE ||
                            {mem_wren, mem_rden, mem_addr} !== {exp_wr, !exp_wr, exp_addr}) begin
                            failures++;
                            $display("[TB] FAIL rand_grant %0d: wren/rden/addr=%b/%b/%h want side %0d %b/%b/%h",
                                     n_grants, mem_wren, mem_rden, mem_addr, exp_side, exp_wr, !exp_wr, exp_addr);
                        end
                        if (exp_wr) begin
                            checks++;
                            if (mem_wdata !== p_d_wdata) begin
                                failures++;
                                $display("[TB] FAIL rand_wdata %0d: got %h want %h", n_grants, mem_wdata, p_d_wdata);
                            end
                        end
                        last_d     = (exp_side == SIDE_D);
                        pend_side  = exp_side;
                        pend_wr    = exp_wr;
                        pend_addr  = exp_addr;
                        pend_wdata = p_d_wdata;
                        n_grants++;
                    end
                    if (p_mem_ready && pend_side != SIDE_NONE) begin
                        if (pend_side == SIDE_D) begin
                            if (pend_wr) ref_mem[pend_addr] = pend_wdata;
                            else         exp_d = ref_mem[pend_addr];
                        end else begin
                            exp_i = ref_mem[pend_addr];
                        end
                        checks++;
                        if ({dmem_ready, imem_ready} !== ((pend_side == SIDE_D) ? 2'b10 : 2'b01)) begin
                            failures++;
                            $display("[TB] FAIL rand_ready: d/i ready=%b/%b want side %0d",
                                     dmem_ready, imem_ready, pend_side);
                        end
                        checks++;
                        if (dmem_rdata !== exp_d || imem_rdata !== exp_i) begin
                            failures++;
                            $display("[TB] FAIL rand_rdata: d=%h i=%h want d=%h i=%h", dmem_rdata, imem_rdata, exp_d, exp_i);
                        end
                        pend_side = SIDE_NONE;
                    end else begin
                        checks++;
                        if ({dmem_ready, imem_ready} !== 2'b00) begin
                            failures++;
                            $display("[TB] FAIL rand_stray_ready: d/i ready=%b/%b want 0/0", dmem_ready, imem_ready);
                        end
                    end
                    p_d_req     = dmem_wren || dmem_rden;
                    p_d_wr      = dmem_wren;
                    p_d_addr    = dmem_addr;
                    p_d_wdata   = dmem_wdata;
                    p_i_req     = imem_rden;
                    p_i_addr    = imem_addr;
                    p_mem_req   = mem_rden || mem_wren;
                    p_mem_ready = mem_ready;
                end
            end
        join
        checks++;
        if (n_grants != 24 || pend_side != SIDE_NONE) begin
            failures++;
            $display("[TB] FAIL rand_totals: grants=%0d pending=%0d want 24 and 0", n_grants, pend_side);
        end
        mem_lat_rand = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        dmem_wren = 1'b0; dmem_rden = 1'b0; dmem_addr = '0; dmem_wdata = '0;
        imem_rden = 1'b0; imem_addr = '0;
        for (int a = 0; a < 1024; a++) dram[a] = init_line(a);
        #1;
        test_reset();
        test_d_read();
        test_simultaneous();
        test_round_robin();
        test_reset_mid_op();
        test_spurious_ready();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
